// File: rtl/bcd_to_binary_if.sv
// Operand/result bundle for the packed-BCD to binary converter.
// Handshake: the requester raises START with BCD valid; it is taken on any edge
// where the converter is idle (BUSY=0), otherwise dropped. DONE pulses for one
// cycle when BINARY/ERROR/OVERFLOW carry the new result; they hold until the next DONE.
interface bcd_to_binary_if #(
  parameter int DECIMAL_DIGITS = 8,
  parameter int OUTPUT_WIDTH   = 32
);
  logic [DECIMAL_DIGITS*4-1:0] BCD;
  logic                        START;
  logic [OUTPUT_WIDTH-1:0]     BINARY;
  logic                        ERROR;
  logic                        OVERFLOW;
  logic                        BUSY;
  logic                        DONE;

  modport master (
    output BCD, START,
    input  BINARY, ERROR, OVERFLOW, BUSY, DONE
  );

  modport slave (
    input  BCD, START,
    output BINARY, ERROR, OVERFLOW, BUSY, DONE
  );
endinterface

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to binary converter (reverse double-dabble: shift right,
// then subtract 3 from every BCD digit that is 8 or more, one digit per cycle).
module bcd_to_binary #(
  parameter int DECIMAL_DIGITS = 8,
  parameter int OUTPUT_WIDTH   = 32
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  bcd_to_binary_if.slave       bus,
  output logic [2:0]           DEBUG_STATE
);

  localparam int N   = DECIMAL_DIGITS;
  localparam int W   = OUTPUT_WIDTH;
  localparam int BW  = 4 * N;
  localparam int SCW = $clog2(W + 1);
  localparam int DIW = (N > 1) ? $clog2(N) : 1;

  localparam logic [SCW-1:0] SC_LAST = SCW'(W);
  localparam logic [DIW-1:0] DI_LAST = DIW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_VALIDATE = 3'd1,
    S_SHIFT    = 3'd2,
    S_ADJUST   = 3'd3,
    S_FINISH   = 3'd4
  } state_t;

  state_t         state;
  state_t         state_next;

  logic [BW-1:0]  bcd_reg;
  logic [W-1:0]   bin_reg;
  logic [SCW-1:0] shift_count;
  logic [SCW-1:0] shift_count_inc;
  logic [DIW-1:0] digit_index;
  logic           err;

  logic           bad_digit;
  logic [BW-1:0]  bcd_adj;

  assign shift_count_inc = shift_count + SCW'(1);

  // Any digit above 9 makes the whole operand invalid.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (bcd_reg[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // Only the digit selected by digit_index is corrected this cycle; no borrow
  // crosses into the neighbouring digit.
  always_comb begin
    bcd_adj = bcd_reg;
    for (int i = 0; i < N; i++) begin
      if ((DIW'(i) == digit_index) && (bcd_reg[4*i +: 4] >= 4'd8)) begin
        bcd_adj[4*i +: 4] = bcd_reg[4*i +: 4] - 4'd3;
      end
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RESETN) state <= S_IDLE;
    else         state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (bus.START) state_next = S_VALIDATE;
      S_VALIDATE: state_next = bad_digit ? S_FINISH : S_SHIFT;
      S_SHIFT:    state_next = (shift_count_inc == SC_LAST) ? S_FINISH : S_ADJUST;
      S_ADJUST:   if (digit_index == DI_LAST) state_next = S_SHIFT;
      S_FINISH:   state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    bus.BUSY    = (state != S_IDLE);
    DEBUG_STATE = state;
  end

  // Working register, counters and registered results
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      bcd_reg      <= '0;
      bin_reg      <= '0;
      shift_count  <= '0;
      digit_index  <= '0;
      err          <= 1'b0;
      bus.BINARY   <= '0;
      bus.ERROR    <= 1'b0;
      bus.OVERFLOW <= 1'b0;
      bus.DONE     <= 1'b0;
    end else begin
      bus.DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.START) begin
            bcd_reg     <= bus.BCD;
            bin_reg     <= '0;
            shift_count <= '0;
            digit_index <= '0;
            err         <= 1'b0;
          end
        end
        S_VALIDATE: begin
          err <= bad_digit;
        end
        S_SHIFT: begin
          {bcd_reg, bin_reg} <= {1'b0, bcd_reg, bin_reg[W-1:1]};
          shift_count        <= shift_count_inc;
        end
        S_ADJUST: begin
          bcd_reg     <= bcd_adj;
          digit_index <= (digit_index == DI_LAST) ? '0 : digit_index + DIW'(1);
        end
        S_FINISH: begin
          // Whatever is left in bcd_reg after W shifts is the part of the value
          // at or above 2^W.
          if (err) begin
            bus.BINARY   <= '0;
            bus.ERROR    <= 1'b1;
            bus.OVERFLOW <= 1'b0;
          end else begin
            bus.BINARY   <= bin_reg;
            bus.ERROR    <= 1'b0;
            bus.OVERFLOW <= (bcd_reg != '0);
          end
          bus.DONE <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed bench for bcd_to_binary in three sizes: (W=32,N=8), (W=16,N=5), (W=8,N=3).
module tb_bcd_to_binary;

  logic clk;
  logic rstn;
  logic [2:0] dbg_a, dbg_b, dbg_c;

  int checks   = 0;
  int failures = 0;

  bcd_to_binary_if #(.DECIMAL_DIGITS(8), .OUTPUT_WIDTH(32)) if_a ();
  bcd_to_binary_if #(.DECIMAL_DIGITS(5), .OUTPUT_WIDTH(16)) if_b ();
  bcd_to_binary_if #(.DECIMAL_DIGITS(3), .OUTPUT_WIDTH(8))  if_c ();

  bcd_to_binary #(.DECIMAL_DIGITS(8), .OUTPUT_WIDTH(32)) dut_a (
    .CLK(clk), .RESETN(rstn), .bus(if_a.slave), .DEBUG_STATE(dbg_a));
  bcd_to_binary #(.DECIMAL_DIGITS(5), .OUTPUT_WIDTH(16)) dut_b (
    .CLK(clk), .RESETN(rstn), .bus(if_b.slave), .DEBUG_STATE(dbg_b));
  bcd_to_binary #(.DECIMAL_DIGITS(3), .OUTPUT_WIDTH(8)) dut_c (
    .CLK(clk), .RESETN(rstn), .bus(if_c.slave), .DEBUG_STATE(dbg_c));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-instance accessors so one driver task covers all three sizes
  function automatic logic get_done(input int sel);
    case (sel)
      0:       return if_a.DONE;
      1:       return if_b.DONE;
      default: return if_c.DONE;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return if_a.BUSY;
      1:       return if_b.BUSY;
      default: return if_c.BUSY;
    endcase
  endfunction

  function automatic logic [63:0] get_bin(input int sel);
    case (sel)
      0:       return 64'(if_a.BINARY);
      1:       return 64'(if_b.BINARY);
      default: return 64'(if_c.BINARY);
    endcase
  endfunction

  function automatic logic [1:0] get_flags(input int sel);
    case (sel)
      0:       return {if_a.ERROR, if_a.OVERFLOW};
      1:       return {if_b.ERROR, if_b.OVERFLOW};
      default: return {if_c.ERROR, if_c.OVERFLOW};
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       if_a.START = v;
      1:       if_b.START = v;
      default: if_c.START = v;
    endcase
  endtask

  task automatic set_bcd(input int sel, input logic [63:0] v);
    case (sel)
      0:       if_a.BCD = v[31:0];
      1:       if_b.BCD = v[19:0];
      default: if_c.BCD = v[11:0];
    endcase
  endtask

  // Driver: one-cycle START, optional extra START pulses at cycles inj0/inj1 of
  // the busy period, then wait (bounded) for DONE and check everything.
  task automatic run_conv(input string tag, input int sel, input logic [63:0] bcd,
                          input logic [63:0] exp_bin, input logic exp_err,
                          input logic exp_ovf, input int exp_lat,
                          input int inj0, input int inj1);
    int cyc;
    int busy_cnt;
    logic done_seen;
    logic [63:0] exp_q[$];
    repeat ($urandom_range(0, 3)) @(negedge clk);
    exp_q.push_back(exp_bin);
    set_bcd(sel, bcd);
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    set_bcd(sel, ~bcd);
    cyc = 0;
    busy_cnt = 0;
    done_seen = 1'b0;
    while (cyc <= 400) begin
      if (get_done(sel)) begin
        done_seen = 1'b1;
        break;
      end
      if (get_busy(sel)) busy_cnt++;
      set_start(sel, (cyc == inj0) || (cyc == inj1));
      @(negedge clk);
      cyc++;
    end
    set_start(sel, 1'b0);
    check_val({tag, ".done_seen"}, 64'(done_seen), 64'd1);
    check_val({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
    check_val({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    check_val({tag, ".binary"}, get_bin(sel), exp_q.pop_front());
    check_val({tag, ".err_ovf"}, 64'(get_flags(sel)), 64'({exp_err, exp_ovf}));
    @(negedge clk);
    check_val({tag, ".done_one_cycle"}, 64'(get_done(sel)), 64'd0);
    check_val({tag, ".idle_after"}, 64'(get_busy(sel)), 64'd0);
  endtask

  initial begin
    logic [31:0] nxt [3];
    logic [31:0] expv [3];
    int n;
    int done_cnt;
    logic found;

    rstn = 1'b0;
    if_a.START = 1'b0; if_a.BCD = '0;
    if_b.START = 1'b0; if_b.BCD = '0;
    if_c.START = 1'b0; if_c.BCD = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    check_val("reset.binary_a", 64'(if_a.BINARY), 64'd0);
    check_val("reset.flags_a", 64'({if_a.ERROR, if_a.OVERFLOW}), 64'd0);
    check_val("reset.busy_done_a", 64'({if_a.BUSY, if_a.DONE}), 64'd0);
    check_val("reset.state_a", 64'(dbg_a), 64'd0);
    check_val("reset.binary_b", 64'(if_b.BINARY), 64'd0);
    check_val("reset.binary_c", 64'(if_c.BINARY), 64'd0);

    // Main function, W=32 N=8
    run_conv("a_max", 0, 64'h99999999, 64'h05F5E0FF, 1'b0, 1'b0, 282, -1, -1);
    run_conv("a_bad_a123", 0, 64'h0000A123, 64'h0, 1'b1, 1'b0, 2, -1, -1);
    run_conv("a_bad_f", 0, 64'h0000000F, 64'h0, 1'b1, 1'b0, 2, -1, -1);
    run_conv("a_bad_f0", 0, 64'hF0000000, 64'h0, 1'b1, 1'b0, 2, -1, -1);
    run_conv("a_zero", 0, 64'h0, 64'h0, 1'b0, 1'b0, 282, -1, -1);
    run_conv("a_one", 0, 64'h1, 64'h1, 1'b0, 1'b0, 282, -1, -1);

    // START pulses mid-conversion must be ignored
    run_conv("a_inject", 0, 64'h12345678, 64'h00BC614E, 1'b0, 1'b0, 282, 5, 100);

    // W=16 N=5, including overflow wrap
    run_conv("b_65535", 1, 64'h65535, 64'hFFFF, 1'b0, 1'b0, 93, -1, -1);
    run_conv("b_65536", 1, 64'h65536, 64'h0000, 1'b0, 1'b1, 93, -1, -1);
    run_conv("b_99999", 1, 64'h99999, 64'h869F, 1'b0, 1'b1, 93, -1, -1);

    // W=8 N=3 boundary
    run_conv("c_255", 2, 64'h255, 64'hFF, 1'b0, 1'b0, 31, -1, -1);
    run_conv("c_256", 2, 64'h256, 64'h00, 1'b0, 1'b1, 31, -1, -1);

    // START held high: back-to-back conversions, BCD re-sampled at each acceptance
    nxt  = '{32'h87654321, 32'h00000999, 32'h11111111};
    expv = '{32'h0000007B, 32'h05397FB1, 32'h000003E7};
    @(negedge clk);
    if_a.BCD = 32'h00000123;
    if_a.START = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      found = 1'b0;
      while (n < 400) begin
        @(negedge clk);
        if (n == 10) if_a.BCD = nxt[k];
        if (if_a.DONE) begin
          found = 1'b1;
          break;
        end
        n++;
      end
      if (k == 2) if_a.START = 1'b0;
      check_val($sformatf("b2b%0d.done_seen", k), 64'(found), 64'd1);
      check_val($sformatf("b2b%0d.latency", k), 64'(n), 64'd282);
      check_val($sformatf("b2b%0d.binary", k), 64'(if_a.BINARY), 64'(expv[k]));
    end
    @(negedge clk);
    check_val("b2b.idle_after", 64'(if_a.BUSY), 64'd0);

    // Reset in the middle of a conversion
    if_a.BCD = 32'h12345678;
    if_a.START = 1'b1;
    @(negedge clk);
    if_a.START = 1'b0;
    repeat (50) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    check_val("midrst.busy", 64'(if_a.BUSY), 64'd0);
    check_val("midrst.done", 64'(if_a.DONE), 64'd0);
    check_val("midrst.binary", 64'(if_a.BINARY), 64'd0);
    check_val("midrst.state", 64'(dbg_a), 64'd0);
    done_cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (if_a.DONE) done_cnt++;
    end
    check_val("midrst.no_done", 64'(done_cnt), 64'd0);
    run_conv("a_after_rst", 0, 64'h00000042, 64'h2A, 1'b0, 1'b0, 282, -1, -1);

    // Reset and START on the same edge: reset wins
    @(negedge clk);
    rstn = 1'b0;
    if_a.BCD = 32'h00000005;
    if_a.START = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    if_a.START = 1'b0;
    check_val("rst_start.busy", 64'(if_a.BUSY), 64'd0);
    @(negedge clk);
    check_val("rst_start.still_idle", 64'(if_a.BUSY), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
